// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg: shared FSM encoding and pattern constants for the SRAM BIST sequencer.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_e;

  localparam int RD_LAT_MAX = 4;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Galois feedback mask for a right-shifting LFSR of the given width
  function automatic logic [63:0] lfsr_taps(input int dw);
    logic [63:0] taps;
    case (dw)
      32'sd8:  taps = 64'h0000_0000_0000_00B8;
      32'sd16: taps = 64'h0000_0000_0000_B400;
      32'sd32: taps = {32'h0000_0000, LFSR_TAPS_32};
      default: taps = {32'h0000_0000, LFSR_TAPS_32};
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/sram_bist_pattern_gen.sv
// sram_bist_pattern_gen: registered pattern source, loaded with a seed and stepped per word.
// SRAM_BIST_LFSR_EN selects a Galois LFSR; otherwise the pattern is seed + word index.
module sram_bist_pattern_gen
  import sram_bist_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [DW-1:0] seed,
  output logic [DW-1:0] pattern
);

  logic [DW-1:0] pattern_d;
  logic [DW-1:0] pattern_q;

`ifdef SRAM_BIST_LFSR_EN
  localparam logic [DW-1:0] TAPS = DW'(lfsr_taps(DW));

  // LFSR load/step; an all-zero seed would lock up, so it becomes 1
  always_comb begin
    pattern_d = pattern_q;
    if (load) begin
      pattern_d = (seed == {DW{1'b0}}) ? {{(DW-1){1'b0}}, 1'b1} : seed;
    end else if (step) begin
      pattern_d = (pattern_q >> 1) ^ (pattern_q[0] ? TAPS : {DW{1'b0}});
    end else begin
      pattern_d = pattern_q;
    end
  end
`else
  // additive pattern: stepping once per word yields seed + index
  always_comb begin
    pattern_d = pattern_q;
    if (load) begin
      pattern_d = seed;
    end else if (step) begin
      pattern_d = pattern_q + DW'(1);
    end else begin
      pattern_d = pattern_q;
    end
  end
`endif

  // pattern register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= {DW{1'b0}};
    end else begin
      pattern_q <= pattern_d;
    end
  end

  assign pattern = pattern_q;

endmodule

// File: rtl/sram_bist_sequencer.sv
// sram_bist_sequencer: writes a pattern to every SRAM word, waits, reads back and compares.
// Pattern type is chosen by SRAM_BIST_LFSR_EN (see sram_bist_pattern_gen).
module sram_bist_sequencer
  import sram_bist_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int DEPTH   = 256,
  parameter int RD_LAT  = 1,
  parameter int GAP_CYC = 10,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] pat_seed,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          mem_rd,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_cnt,
  output logic [AW-1:0] first_err_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam int CNT_MAX = (GAP_CYC > RD_LAT) ? GAP_CYC : RD_LAT;
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LAT - 1);
  localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};

  bist_state_e state_d, state_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [DW-1:0] seed_d, seed_q;
  logic [CW-1:0] err_cnt_d, err_cnt_q;
  logic [AW-1:0] first_err_d, first_err_q;
  logic mem_we_d, mem_we_q, mem_rd_d, mem_rd_q;
  logic busy_d, busy_q, done_d, done_q, pass_d, pass_q;
  logic [RD_LAT-1:0] vld_pipe_d, vld_pipe_q;
  logic [AW-1:0] addr_pipe_d [RD_LAT];
  logic [AW-1:0] addr_pipe_q [RD_LAT];

  logic start_ok, cmp_valid, mismatch, exp_load;
  logic [AW-1:0] cmp_addr;
  logic [DW-1:0] wr_pattern, exp_pattern;

  assign start_ok  = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign cmp_valid = vld_pipe_q[RD_LAT-1];
  assign cmp_addr  = addr_pipe_q[RD_LAT-1];
  assign mismatch  = cmp_valid && !abort && (mem_rdata != exp_pattern);
  assign exp_load  = (state_d == ST_READ) && (state_q != ST_READ);

  sram_bist_pattern_gen #(.DW(DW)) u_wr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (start_ok),
    .step    (state_q == ST_WRITE),
    .seed    (pat_seed),
    .pattern (wr_pattern)
  );

  sram_bist_pattern_gen #(.DW(DW)) u_exp_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (exp_load),
    .step    (cmp_valid),
    .seed    (seed_q),
    .pattern (exp_pattern)
  );

  // next-state, address and phase-counter logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = ST_IDLE;
      addr_d  = {AW{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_WRITE;
            addr_d  = {AW{1'b0}};
          end else begin
            state_d = state_q;
          end
        end
        ST_WRITE: begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = {AW{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = (GAP_CYC == 0) ? ST_READ : ST_GAP;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_READ;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = {AW{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        ST_DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          addr_d  = {AW{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // outputs decoded from the next state so the registered copies line up with the state
  always_comb begin
    mem_we_d = (state_d == ST_WRITE);
    mem_rd_d = (state_d == ST_READ);
    busy_d   = (state_d == ST_WRITE) || (state_d == ST_GAP) ||
               (state_d == ST_READ)  || (state_d == ST_DRAIN);
    done_d   = (state_d == ST_DONE);
    pass_d   = done_d && (err_cnt_d == {CW{1'b0}});
  end

  // read-latency pipeline and error bookkeeping
  always_comb begin
    seed_d      = seed_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    vld_pipe_d  = vld_pipe_q;
    for (int i = RD_LAT - 1; i > 0; i--) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      addr_pipe_d[i] = addr_pipe_q[i-1];
    end
    vld_pipe_d[0]  = mem_rd_q;
    addr_pipe_d[0] = addr_q;
    if (abort) begin
      vld_pipe_d = {RD_LAT{1'b0}};
    end else if (start_ok) begin
      seed_d      = pat_seed;
      err_cnt_d   = {CW{1'b0}};
      first_err_d = {AW{1'b0}};
    end else if (mismatch) begin
      err_cnt_d   = (err_cnt_q == ERR_MAX) ? ERR_MAX : err_cnt_q + CW'(1);
      first_err_d = (err_cnt_q == {CW{1'b0}}) ? cmp_addr : first_err_q;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= {AW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      seed_q      <= {DW{1'b0}};
      err_cnt_q   <= {CW{1'b0}};
      first_err_q <= {AW{1'b0}};
      mem_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      vld_pipe_q  <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        addr_pipe_q[i] <= {AW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      seed_q      <= seed_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      mem_we_q    <= mem_we_d;
      mem_rd_q    <= mem_rd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      vld_pipe_q  <= vld_pipe_d;
      for (int i = 0; i < RD_LAT; i++) begin
        addr_pipe_q[i] <= addr_pipe_d[i];
      end
    end
  end

  assign mem_addr       = addr_q;
  assign mem_we         = mem_we_q;
  assign mem_rd         = mem_rd_q;
  assign mem_wdata      = wr_pattern;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_sram_bist_sequencer.sv
// tb_sram_bist_sequencer: directed bench for two sequencer builds (RD_LAT=1/GAP=10 and RD_LAT=3/GAP=0)
// each driving its own behavioural SRAM with injectable read faults.
module tb_sram_bist_sequencer;

  localparam int LAT1 = 524;  // 1 + 256 + 10 + 256 + 1
  localparam int LAT3 = 516;  // 1 + 256 + 0 + 256 + 3

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  logic [31:0] pat_seed;
  logic stuck_en, multi_en;

  logic [7:0]  addr1, first1, addr3, first3;
  logic        we1, rd1, busy1, done1, pass1, we3, rd3, busy3, done3, pass3;
  logic [31:0] wdata1, rdata1, wdata3, rdata3;
  logic [15:0] err1, err3;

  int n_checks = 0;
  int n_errors = 0;

  sram_bist_sequencer u1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pat_seed(pat_seed),
    .mem_addr(addr1), .mem_we(we1), .mem_rd(rd1), .mem_wdata(wdata1), .mem_rdata(rdata1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .first_err_addr(first1)
  );

  sram_bist_sequencer #(.RD_LAT(3), .GAP_CYC(0)) u3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pat_seed(pat_seed),
    .mem_addr(addr3), .mem_we(we3), .mem_rd(rd3), .mem_wdata(wdata3), .mem_rdata(rdata3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .first_err_addr(first3)
  );

  function automatic logic [31:0] fault(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    r = d;
    if (stuck_en && a == 8'h40) r = r | 32'h0000_0008;
    if (multi_en && (a == 8'h10 || a == 8'h20 || a == 8'h30)) r = r ^ 32'h0000_0001;
    return r;
  endfunction

  function automatic logic [31:0] pat_model(input logic [31:0] seed, input int a);
`ifdef SRAM_BIST_LFSR_EN
    logic [31:0] v;
    v = (seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < a; i++) v = (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
    return v;
`else
    return seed + 32'(a);
`endif
  endfunction

  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] rp1;
  logic [31:0] rp3 [3];
  int we_cnt1 = 0, we_cnt3 = 0, rd_cnt1 = 0, rd_cnt3 = 0, both_cnt = 0;

  always @(posedge clk) begin
    if (we1) mem1[addr1] <= wdata1;
    if (rd1) rp1 <= fault(addr1, mem1[addr1]);
    if (we3) mem3[addr3] <= wdata3;
    if (rd3) rp3[0] <= fault(addr3, mem3[addr3]);
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
    we_cnt1  <= we_cnt1 + (we1 ? 1 : 0);
    we_cnt3  <= we_cnt3 + (we3 ? 1 : 0);
    rd_cnt1  <= rd_cnt1 + (rd1 ? 1 : 0);
    rd_cnt3  <= rd_cnt3 + (rd3 ? 1 : 0);
    both_cnt <= both_cnt + (((we1 && rd1) || (we3 && rd3)) ? 1 : 0);
  end
  assign rdata1 = rp1;
  assign rdata3 = rp3[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [31:0] seed);
    @(negedge clk);
    pat_seed = seed;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // returns the cycle (start cycle = 0) on which each done was first seen high, -1 on timeout
  task automatic wait_done(input int n0, output int t1, output int t3);
    int n;
    n = n0;
    t1 = -1;
    t3 = -1;
    while ((t1 < 0 || t3 < 0) && n < 3000) begin
      @(posedge clk);
      #1 n++;
      if (done1 && t1 < 0) t1 = n + 1;
      if (done3 && t3 < 0) t3 = n + 1;
    end
  endtask

  int t1, t3, n, b_we1, b_we3, b_rd1, b_rd3;
  logic [31:0] exp_stuck;
  logic [31:0] seed_v;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; pat_seed = 32'd0;
    stuck_en = 1'b0; multi_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags1", {27'd0, busy1, done1, pass1, we1, rd1}, 32'd0);
    check("rst_err1", {16'd0, err1}, 32'd0);
    check("rst_addr1", {16'd0, first1, addr1}, 32'd0);
    check("rst_wdata1", wdata1, 32'd0);
    check("rst_flags3", {27'd0, busy3, done3, pass3, we3, rd3}, 32'd0);
    @(negedge clk) rst = 1'b1;

    // clean run, seed 0
    b_we1 = we_cnt1; b_we3 = we_cnt3; b_rd1 = rd_cnt1; b_rd3 = rd_cnt3;
    run_start(32'd0);
    check("busy_after_start", {31'd0, busy1}, 32'd1);
    wait_done(0, t1, t3);
    check("clean_lat1", t1, LAT1);
    check("clean_lat3", t3, LAT3);
    check("clean_pass1", {31'd0, pass1}, 32'd1);
    check("clean_err1", {16'd0, err1}, 32'd0);
    check("clean_pass3", {31'd0, pass3}, 32'd1);
    check("clean_busy1", {31'd0, busy1}, 32'd0);
    check("clean_we1", we_cnt1 - b_we1, 32'd256);
    check("clean_rd1", rd_cnt1 - b_rd1, 32'd256);
    check("clean_we3", we_cnt3 - b_we3, 32'd256);
    check("clean_rd3", rd_cnt3 - b_rd3, 32'd256);
    check("clean_mem1_0", mem1[0], pat_model(32'd0, 0));
    check("clean_mem1_255", mem1[255], pat_model(32'd0, 255));
    check("clean_mem3_128", mem3[128], pat_model(32'd0, 128));

    // stuck bit 3 at address 0x40, seed 0x100 (pattern 0x140 has bit 3 clear)
    stuck_en = 1'b1;
    exp_stuck = ((pat_model(32'h100, 64) & 32'h8) != 32'd0) ? 32'd0 : 32'd1;
    run_start(32'h0000_0100);
    wait_done(0, t1, t3);
    stuck_en = 1'b0;
    check("stuck_err1", {16'd0, err1}, exp_stuck);
    check("stuck_first1", {24'd0, first1}, (exp_stuck == 32'd1) ? 32'h40 : 32'h0);
    check("stuck_pass1", {31'd0, pass1}, (exp_stuck == 32'd1) ? 32'd0 : 32'd1);
    check("stuck_err3", {16'd0, err3}, exp_stuck);
    check("stuck_first3", {24'd0, first3}, (exp_stuck == 32'd1) ? 32'h40 : 32'h0);

    // three corrupted words; start from DONE clears done
    multi_en = 1'b1;
    run_start(32'h1234_5678);
    check("restart_done1", {31'd0, done1}, 32'd0);
    check("restart_err1", {16'd0, err1}, 32'd0);
    wait_done(0, t1, t3);
    check("multi_lat1", t1, LAT1);
    check("multi_err1", {16'd0, err1}, 32'd3);
    check("multi_first1", {24'd0, first1}, 32'h10);
    check("multi_pass1", {31'd0, pass1}, 32'd0);
    check("multi_err3", {16'd0, err3}, 32'd3);
    check("multi_first3", {24'd0, first3}, 32'h10);

    // abort while u1 reads address 0x80; earlier mismatches stay counted
    run_start(32'h0BAD_F00D);
    n = 0;
    while (!(rd1 && addr1 == 8'h80) && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    check("abort_reach", n, 32'd394);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_rd1", {31'd0, rd1}, 32'd0);
    check("abort_busy1", {31'd0, busy1}, 32'd0);
    check("abort_done1", {31'd0, done1}, 32'd0);
    check("abort_err1", {16'd0, err1}, 32'd3);
    check("abort_first1", {24'd0, first1}, 32'h10);
    check("abort_rd3", {30'd0, busy3, rd3}, 32'd0);
    multi_en = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("abort_idle_rd1", {30'd0, we1, rd1}, 32'd0);

    // clean run after abort, with a wrapping seed and an ignored start mid-WRITE
    seed_v = 32'hFFFF_FFF0;
    b_we1 = we_cnt1; b_we3 = we_cnt3;
    run_start(seed_v);
    repeat (50) @(posedge clk);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("ign_busy1", {30'd0, busy1, we1}, 32'd3);
    wait_done(51, t1, t3);
    check("ign_lat1", t1, LAT1);
    check("ign_lat3", t3, LAT3);
    check("ign_we1", we_cnt1 - b_we1, 32'd256);
    check("ign_we3", we_cnt3 - b_we3, 32'd256);
    check("ign_pass1", {31'd0, pass1}, 32'd1);
    check("ign_err1", {16'd0, err1}, 32'd0);
    check("ign_first1", {24'd0, first1}, 32'd0);
    check("ign_mem1_16", mem1[16], pat_model(seed_v, 16));

    // asynchronous reset in the middle of u1's GAP (u3 is reading then)
    run_start(32'h5555_0000);
    repeat (260) @(posedge clk);
    #1;
    check("gap_state1", {29'd0, busy1, we1, rd1}, 32'd4);
    check("gap_rd3", {31'd0, rd3}, 32'd1);
    rst = 1'b0;
    #1;
    check("mrst_flags1", {27'd0, busy1, done1, pass1, we1, rd1}, 32'd0);
    check("mrst_data1", {8'd0, err1, addr1} | {24'd0, first1}, 32'd0);
    check("mrst_wdata1", wdata1, 32'd0);
    check("mrst_flags3", {27'd0, busy3, done3, pass3, we3, rd3}, 32'd0);
    check("mrst_addr3", {24'd0, addr3}, 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("never_both", both_cnt, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_bist_sequencer.md
Name: sram_bist_sequencer

Overview:
- Self-test controller for the on-chip SRAM comparator datapath.
- On `start`: writes a deterministic pattern to every SRAM location, idles for a fixed gap, then reads every location back.
- Compares read data against the regenerated expected pattern and reports pass/fail, error count and first failing address.
- Sits between the top-level control and the SRAM port; owns `we` and `rd` while busy.

Parameters:
- DW, 32, SRAM data width.
- AW, 8, SRAM address width.
- DEPTH, 256, locations tested, addresses 0..DEPTH-1; DEPTH <= 2**AW.
- RD_LAT, 1, cycles from `mem_rd` sampled high to `mem_rdata` valid; legal range 1..4.
- GAP_CYC, 10, idle cycles between write pass and read pass; 0 is legal.
- CW, 16, error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle start request; honoured only in IDLE or DONE.
- abort  in  1  synchronous abort; returns to IDLE.
- pat_seed  in  DW  pattern seed, captured on accepted start.
- mem_addr  out  AW  SRAM address.
- mem_we  out  1  SRAM write enable.
- mem_rd  out  1  SRAM read enable.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data.
- busy  out  1  high from the cycle after an accepted start until DONE or IDLE.
- done  out  1  level; high in DONE, cleared by the next accepted start or by abort.
- pass  out  1  valid while `done`=1; 1 iff err_cnt==0.
- err_cnt  out  CW  mismatch count, saturating at 2**CW-1.
- first_err_addr  out  AW  address of the first mismatch; 0 if none.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters 0.
- FSM states: IDLE, WRITE, GAP, READ, DRAIN, DONE.
- IDLE/DONE + start:
  - capture seed; clear err_cnt, first_err_addr and done;
  - set addr=0;
  - go to WRITE.
- WRITE:
  - drive mem_we=1, mem_addr=addr, mem_wdata=pat(addr);
  - addr increments each cycle;
  - after the cycle with addr==DEPTH-1: go to GAP (GAP_CYC==0: go directly to READ); reset addr to 0.
  - Exactly DEPTH write cycles.
- GAP: mem_we=mem_rd=0 for exactly GAP_CYC cycles, then READ.
- READ:
  - drive mem_rd=1, mem_addr=addr, incrementing each cycle;
  - after addr==DEPTH-1, go to DRAIN.
- DRAIN: wait RD_LAT cycles for in-flight reads, then DONE.
- Compare pipeline:
  - a valid bit and the address are delayed RD_LAT cycles;
  - when the delayed valid is set, compare mem_rdata to pat(delayed addr);
  - on mismatch: increment err_cnt (saturating); if this is the first mismatch, load first_err_addr.
- DONE: busy=0, done=1, pass=(err_cnt==0); outputs held until the next start.
- Pattern (default): pat(a) = seed + zero-extended a, modulo 2**DW.
- Outputs at most one of mem_we/mem_rd per cycle, never both.
- start while busy: ignored.
- abort:
  - takes priority over start and over every state;
  - next state IDLE; mem_we/mem_rd low the next cycle;
  - done=0; err_cnt and first_err_addr retained; in-flight compares discarded.
- Reset mid-operation: immediate return to the reset values; SRAM contents are unspecified.
- Total run latency (start accepted -> done high): 1 + DEPTH + GAP_CYC + DEPTH + RD_LAT cycles.

Optional Feature:
- Macro: SRAM_BIST_LFSR_EN.
- Defined:
  - pattern is a DW-bit Galois LFSR (taps in package), loaded with pat_seed (seed 0 is replaced by 1), stepped once per write;
  - a second identical LFSR, reloaded at entry to READ, steps once per compared word to supply expected data.
- Undefined: additive pattern above; no LFSR logic synthesised.

Decomposition:
- Package sram_bist_pkg holds:
  - FSM state enum;
  - LFSR tap constant per DW (32: 0x80200003);
  - RD_LAT maximum constant.
- One sub-module, sram_bist_pattern_gen:
  - inputs seed, load, step;
  - output pattern;
  - contains either the adder or the LFSR per the macro;
  - instantiated twice, once for the write pass and once for the expected data.

Test Plan:
- Clean run, seed=0, DEPTH=256, RD_LAT=1, GAP_CYC=10, ideal SRAM model -> 256 writes with data 0..255; done after 524 cycles; pass=1, err_cnt=0.
- Stuck bit: model forces bit 3 of address 0x40 to 1, seed=0x100 -> err_cnt=1, first_err_addr=0x40, pass=0.
- Multi-fault: model corrupts addresses 0x10, 0x20, 0x30 -> err_cnt=3, first_err_addr=0x10; RD_LAT=3 variant gives the same result.
- Abort during READ at addr 0x80 -> mem_rd low the next cycle, busy=0, done=0; a following start completes a normal run with pass=1.
- start pulsed during WRITE -> ignored; exactly 256 mem_we cycles observed; rst pulled low mid-GAP -> all outputs 0 immediately.
- SRAM_BIST_LFSR_EN defined, seed=0 -> the first write data is the LFSR value from seed 1; clean run pass=1.
